// File: rtl/bank_readout_scheduler.sv
// rtl/bank_readout_scheduler.sv - drains ping-pong capture banks oldest-first onto a valid/ready stream.
// Optional READOUT_HEADER_EN prepends a {bank, len} header word (flagged by out_first) to each job.
module bank_readout_scheduler #(
    parameter int DEPTH  = 200,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bank0_full,
    input  logic              bank1_full,
    input  logic              mem_done,
    input  logic              wr_bank,
    input  logic [7:0]        idx_final,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
`ifdef READOUT_HEADER_EN
    output logic              out_first,
`endif
    output logic              job_bank,
    output logic              busy,
    output logic [1:0]        bank_release,
    output logic              overrun
);

    localparam int IDX_W = ADDR_W - 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_READ, S_DRAIN, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_pending;
    logic                r_first;
    logic [ADDR_W-1:0]   r_len0;
    logic [ADDR_W-1:0]   r_len1;
    logic                r_job_bank;
    logic [ADDR_W-1:0]   r_job_len;
    logic [IDX_W-1:0]    r_idx;
    logic                r_rd_pend;
    logic                r_rd_last;
    logic                r_overrun;
    logic [DATA_W-1:0]   r_fifo_data [2];
    logic [1:0]          r_fifo_last;
    logic                r_wptr;
    logic                r_rptr;
    logic [1:0]          r_cnt;

    logic [1:0]          w_req;
    logic [1:0]          w_clash;
    logic [1:0]          w_active;
    logic [1:0]          w_accept;
    logic [1:0]          w_drop;
    logic [1:0]          w_pend_clr;
    logic [1:0]          w_pend_nxt;
    logic                w_first_nxt;
    logic                w_act;
    logic                w_load;
    logic [ADDR_W-1:0]   w_done_len;
    logic [ADDR_W-1:0]   w_sel_len;
    logic                w_pop;
    logic                w_push;
    logic [DATA_W-1:0]   w_push_data;
    logic                w_push_last;
    logic [2:0]          w_occ;
    logic                w_rd_en;
    logic                w_rd_last;

    // Full wins over a same-cycle end-of-capture for the same bank; the loser is an overrun.
    assign w_req      = {bank1_full | (mem_done & wr_bank), bank0_full | (mem_done & ~wr_bank)};
    assign w_clash    = {bank1_full & mem_done & wr_bank, bank0_full & mem_done & ~wr_bank};
    assign w_act      = (r_state == S_READ) || (r_state == S_DRAIN) || (r_state == S_DONE);
    assign w_active   = {w_act & r_job_bank, w_act & ~r_job_bank};
    assign w_accept   = w_req & ~(r_pending | w_active);
    assign w_drop     = (w_req & (r_pending | w_active)) | w_clash;
    assign w_done_len = ADDR_W'(idx_final) + ADDR_W'(1);
    assign w_load     = (r_state == S_LOAD);
    assign w_sel_len  = r_first ? r_len1 : r_len0;

    // r_first always names the oldest pending bank, so LOAD simply takes it.
    assign w_pend_clr = r_pending & ~(w_load ? (r_first ? 2'b10 : 2'b01) : 2'b00);
    assign w_pend_nxt = w_pend_clr | w_accept;

    always_comb begin
        w_first_nxt = r_first;
        case (w_pend_clr)
            2'b00:   w_first_nxt = ~w_accept[0];
            2'b01:   w_first_nxt = 1'b0;
            2'b10:   w_first_nxt = 1'b1;
            default: w_first_nxt = r_first;
        endcase
    end

    assign w_pop     = out_valid & out_ready;
    assign w_occ     = {1'b0, r_cnt} + {2'b00, r_rd_pend};
    assign w_rd_en   = (r_state == S_READ) && (w_occ < (3'd2 + {2'b00, w_pop}));
    assign w_rd_last = w_rd_en && ({1'b0, r_idx} == (r_job_len - ADDR_W'(1)));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (|w_pend_nxt) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_READ;
            S_READ:  if (w_rd_last) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_pop && out_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending  <= 2'b00;
            r_first    <= 1'b0;
            r_len0     <= '0;
            r_len1     <= '0;
            r_job_bank <= 1'b0;
            r_job_len  <= '0;
            r_idx      <= '0;
            r_rd_pend  <= 1'b0;
            r_rd_last  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_pending <= w_pend_nxt;
            r_first   <= w_first_nxt;
            r_overrun <= |w_drop;
            if (w_accept[0]) r_len0 <= bank0_full ? ADDR_W'(DEPTH) : w_done_len;
            if (w_accept[1]) r_len1 <= bank1_full ? ADDR_W'(DEPTH) : w_done_len;
            if (w_load) begin
                r_job_bank <= r_first;
                r_job_len  <= w_sel_len;
                r_idx      <= '0;
            end else if (w_rd_en && !w_rd_last) begin
                r_idx <= r_idx + IDX_W'(1);
            end
            r_rd_pend <= w_rd_en;
            r_rd_last <= w_rd_last;
        end
    end

`ifdef READOUT_HEADER_EN
    logic [1:0] r_fifo_first;
    // The previous job has fully drained before LOAD, so the header never collides with read data.
    assign w_push      = r_rd_pend | w_load;
    assign w_push_data = w_load ? {r_first, w_sel_len, {(DATA_W-ADDR_W-1){1'b0}}} : rd_data;
    assign w_push_last = w_load ? 1'b0 : r_rd_last;
    assign out_first   = out_valid & r_fifo_first[r_rptr];

    always_ff @(posedge clk) begin
        if (reset)       r_fifo_first <= 2'b00;
        else if (w_push) r_fifo_first[r_wptr] <= w_load;
    end
`else
    assign w_push      = r_rd_pend;
    assign w_push_data = rd_data;
    assign w_push_last = r_rd_last;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_fifo_last    <= 2'b00;
            r_wptr         <= 1'b0;
            r_rptr         <= 1'b0;
            r_cnt          <= 2'b00;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wptr] <= w_push_data;
                r_fifo_last[r_wptr] <= w_push_last;
                r_wptr              <= ~r_wptr;
            end
            if (w_pop) r_rptr <= ~r_rptr;
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign out_valid    = (r_cnt != 2'b00);
    assign out_data     = r_fifo_data[r_rptr];
    assign out_last     = out_valid & r_fifo_last[r_rptr];
    assign rd_en        = w_rd_en;
    assign rd_addr      = (r_state == S_READ) ? {r_job_bank, r_idx} : '0;
    assign job_bank     = r_job_bank;
    assign busy         = (r_state != S_IDLE) || out_valid;
    assign bank_release = (r_state == S_DONE) ? (r_job_bank ? 2'b10 : 2'b01) : 2'b00;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_bank_readout_scheduler.sv
// tb/tb_bank_readout_scheduler.sv - directed self-checking bench for bank_readout_scheduler.
module tb_bank_readout_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        bank0_full, bank1_full, mem_done, wr_bank;
    logic [7:0]  idx_final;
    logic [8:0]  rd_addr;
    logic        rd_en;
    logic [15:0] rd_data;
    logic [15:0] out_data;
    logic        out_valid, out_ready, out_last;
    logic        job_bank, busy, overrun;
    logic [1:0]  bank_release;
`ifdef READOUT_HEADER_EN
    logic        out_first;
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    int total = 0;
    int bad   = 0;
    int rel_order[$];
    int ov_cnt = 0;

    always #5 clk = ~clk;

    bank_readout_scheduler dut (
        .clk(clk), .reset(reset),
        .bank0_full(bank0_full), .bank1_full(bank1_full),
        .mem_done(mem_done), .wr_bank(wr_bank), .idx_final(idx_final),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
`ifdef READOUT_HEADER_EN
        .out_first(out_first),
`endif
        .job_bank(job_bank), .busy(busy), .bank_release(bank_release), .overrun(overrun)
    );

    function automatic logic [15:0] ram_f(input logic [8:0] a);
        return 16'(a) * 16'd97 + 16'h1234;
    endfunction

    always @(posedge clk) if (rd_en) rd_data <= ram_f(rd_addr);

    always @(negedge clk) begin
        if (bank_release[0]) rel_order.push_back(0);
        if (bank_release[1]) rel_order.push_back(1);
        if (overrun) ov_cnt <= ov_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic b0, input logic b1, input logic md, input logic wb,
                         input logic [7:0] idx);
        @(negedge clk);
        bank0_full = b0; bank1_full = b1; mem_done = md; wr_bank = wb; idx_final = idx;
        @(negedge clk);
        bank0_full = 0; bank1_full = 0; mem_done = 0; wr_bank = 0; idx_final = 0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic consume(input logic bank, input int len, input bit rnd, input int take,
                           output int cycles);
        int got = 0;
        int cyc = 0;
        int nwords = len + HDR;
        bit pstall = 0;
        logic [15:0] pdata = '0;
        logic [15:0] ed;
        logic el;
        while (got < take && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (pstall) chk("stall_hold", out_data, pdata);
            if (out_valid && out_ready) begin
                if (HDR == 1 && got == 0) begin
                    ed = {bank, 9'(len), 6'b0};
                    el = 1'b0;
                end else begin
                    ed = ram_f({bank, 8'(got - HDR)});
                    el = (got == nwords - 1);
                end
                chk("data", out_data, ed);
                chk("last", out_last, el);
                chk("job_bank", job_bank, bank);
                got++;
            end
            pstall = out_valid && !out_ready;
            pdata  = out_data;
        end
        chk("word_count", got, take);
        cycles = cyc;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int cyc;
        int r0;
        int o0;
        reset = 1; bank0_full = 0; bank1_full = 0; mem_done = 0; wr_bank = 0;
        idx_final = 0; out_ready = 0;
        settle(3);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_release", bank_release, 0);
        chk("rst_overrun", overrun, 0);
        reset = 0;

        // full bank 0 at full rate
        r0 = rel_order.size();
        pulse(1, 0, 0, 0, 0);
`ifndef READOUT_HEADER_EN
        #1 chk("lat_k1", out_valid, 0);
        settle(1); chk("lat_k2", out_valid, 0);
        settle(1); chk("lat_k3", out_valid, 0);
`endif
        consume(0, 200, 0, 200 + HDR, cyc);
`ifndef READOUT_HEADER_EN
        chk("throughput", cyc, 200);
`endif
        settle(3);
        chk("t1_rel_n", rel_order.size() - r0, 1);
        chk("t1_rel_bank", rel_order[r0], 0);
        chk("t1_busy", busy, 0);

        // partial bank 1, 38 words
        r0 = rel_order.size();
        pulse(0, 0, 1, 1, 8'd37);
        consume(1, 38, 0, 38 + HDR, cyc);
        settle(3);
        chk("t2_rel_n", rel_order.size() - r0, 1);
        chk("t2_rel_bank", rel_order[r0], 1);
        chk("t2_busy", busy, 0);

        // bank1 then bank0 three cycles later: strict oldest-first
        r0 = rel_order.size();
        pulse(0, 1, 0, 0, 0);
        @(negedge clk);
        pulse(1, 0, 0, 0, 0);
        consume(1, 200, 0, 200 + HDR, cyc);
        consume(0, 200, 0, 200 + HDR, cyc);
        settle(3);
        chk("t3_rel_n", rel_order.size() - r0, 2);
        chk("t3_rel_first", rel_order[r0], 1);
        chk("t3_rel_second", rel_order[r0 + 1], 0);

        // random backpressure
        r0 = rel_order.size();
        pulse(0, 1, 0, 0, 0);
        consume(1, 200, 1, 200 + HDR, cyc);
        settle(3);
        chk("t4_rel_n", rel_order.size() - r0, 1);

        // duplicate request while active
        r0 = rel_order.size();
        o0 = ov_cnt;
        pulse(1, 0, 0, 0, 0);
        repeat (5) @(negedge clk);
        pulse(1, 0, 0, 0, 0);
        consume(0, 200, 0, 200 + HDR, cyc);
        settle(10);
        chk("t5_overrun", ov_cnt - o0, 1);
        chk("t5_rel_n", rel_order.size() - r0, 1);
        chk("t5_idle_valid", out_valid, 0);
        chk("t5_idle_busy", busy, 0);

        // full and mem_done for bank 1 in one cycle: full length wins
        r0 = rel_order.size();
        o0 = ov_cnt;
        pulse(0, 1, 1, 1, 8'd5);
        consume(1, 200, 0, 200 + HDR, cyc);
        settle(3);
        chk("t6_overrun", ov_cnt - o0, 1);
        chk("t6_rel_bank", rel_order[r0], 1);

        // idx_final = 255 gives a 256-word job
        r0 = rel_order.size();
        pulse(0, 0, 1, 0, 8'd255);
        consume(0, 256, 0, 256 + HDR, cyc);
        settle(3);
        chk("t7_rel_bank", rel_order[r0], 0);
        chk("t7_busy", busy, 0);

        // reset mid-job
        r0 = rel_order.size();
        pulse(1, 0, 0, 0, 0);
        consume(0, 200, 0, 100, cyc);
        reset = 1;
        settle(1);
        chk("t8_valid", out_valid, 0);
        chk("t8_busy", busy, 0);
        chk("t8_rd_en", rd_en, 0);
        reset = 0;
        settle(10);
        chk("t8_no_release", rel_order.size() - r0, 0);
        chk("t8_still_idle", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
